tx_line: RTL and testbench

UART line-speed transmitter, the transmit-side counterpart of the team's UART receiver. Pops bytes from a synchronous transmit FIFO through its read interface and serialises each byte onto UART_TX as 8N1 (1 start, 8 data LSB-first, STOP_BITS stop) at CLK_50MHz/CLKS_PER_BIT baud. Default 434 clocks/bit gives about 115200 baud. Sits between the TX FIFO read port and the board TX pin.

---
 rtl/tx_line.sv | 169 ++++++++++++++++
 tb/tb_tx_line.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tx_line.sv
// tx_line: 8N1 UART transmitter fed from a synchronous TX FIFO read port.
// Define TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit(s).

module tx_line #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       CLK_50MHz,
  input  logic       ARESETn,
  input  logic       fifo_empty,
  output logic       readen,
  input  logic [7:0] data,
  output logic       UART_TX,
  output logic       busy
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned DATA_W = 8;

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_LOAD  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
    S_STOP  = 3'd6
  } state_t;
`endif

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [DATA_W-1:0]   r_shift;
  logic                r_tx;
  logic                r_readen;
  logic                r_busy;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [BIT_W-1:0]    w_bit_cnt_nxt;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                w_tx_nxt;
  logic                w_readen_nxt;
  logic                w_busy_nxt;
  logic                w_terminal;
  logic                w_last_data;
  logic                w_last_stop;

  assign w_terminal  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign w_last_data = (r_bit_cnt == BIT_W'(DATA_W - 1));
  assign w_last_stop = (r_bit_cnt == BIT_W'(STOP_BITS - 1));

  // State and all registered datapath/outputs; reset forces the line idle at once
  always_ff @(posedge CLK_50MHz or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_readen  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      r_readen  <= w_readen_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!fifo_empty) w_state_nxt = S_REQ;
      S_REQ:   w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_START;
      S_START: if (w_terminal) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_terminal && w_last_data) begin
`ifdef TX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef TX_PARITY_EN
      S_PARITY: if (w_terminal) w_state_nxt = S_STOP;
`endif
      S_STOP:  if (w_terminal && w_last_stop) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, shift register and counters
  always_comb begin
    w_cnt_nxt     = r_cnt + CNT_W'(1);
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_tx_nxt      = r_tx;
    w_readen_nxt  = 1'b0;
    w_busy_nxt    = (w_state_nxt != S_IDLE);

    // Bit-period counter restarts on every state entry and on each terminal count
    if ((w_state_nxt != r_state) || w_terminal || (r_state == S_IDLE)) begin
      w_cnt_nxt = '0;
    end

    case (r_state)
      S_IDLE: w_readen_nxt = !fifo_empty;
      S_LOAD: begin
        w_shift_nxt   = data;
        w_tx_nxt      = 1'b0;
        w_bit_cnt_nxt = '0;
      end
      S_START: if (w_terminal) w_tx_nxt = r_shift[0];
      S_DATA: begin
        if (w_terminal) begin
          if (w_last_data) begin
            w_bit_cnt_nxt = '0;
`ifdef TX_PARITY_EN
            w_tx_nxt = ^r_shift;
`else
            w_tx_nxt = 1'b1;
`endif
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
            w_tx_nxt      = r_shift[r_bit_cnt + BIT_W'(1)];
          end
        end
      end
`ifdef TX_PARITY_EN
      S_PARITY: begin
        if (w_terminal) begin
          w_tx_nxt      = 1'b1;
          w_bit_cnt_nxt = '0;
        end
      end
`endif
      S_STOP: begin
        if (w_terminal) begin
          w_bit_cnt_nxt = w_last_stop ? '0 : r_bit_cnt + BIT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign readen  = r_readen;
  assign UART_TX = r_tx;
  assign busy    = r_busy;

endmodule

// File: tb/tb_tx_line.sv
// tb_tx_line: three tx_line instances (4, 8 and 434 clocks/bit) driven from queue-based FIFO
// models with random bytes; a per-instance timeline model predicts readen/busy/UART_TX every cycle.

module tb_tx_line;

`ifdef TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  function automatic int cpb_of(input int i);
    return (i == 0) ? 4 : (i == 1) ? 8 : 434;
  endfunction

  function automatic int sb_of(input int i);
    return (i == 1) ? 2 : 1;
  endfunction

  // Line level of serial bit slot idx within a frame: start, data LSB first, parity, stop
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR == 1 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] readen_s;
  logic [2:0] busy_s;
  logic [2:0] tx_s;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int CPB = cpb_of(g);
    localparam int SB  = sb_of(g);
    localparam int NB  = 9 + PAR + SB;

    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic [7:0] q[$];
    logic [7:0] exp_q[$];

    initial begin
      fifo_empty = 1'b1;
      fifo_data  = 8'h00;
    end

    tx_line #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) u_dut (
      .CLK_50MHz (clk),
      .ARESETn   (rst_n),
      .fifo_empty(fifo_empty),
      .readen    (readen_s[g]),
      .data      (fifo_data),
      .UART_TX   (tx_s[g]),
      .busy      (busy_s[g])
    );

    // Synchronous FIFO: pops on the edge that samples readen, data valid afterwards
    always @(posedge clk) begin
      if (readen_s[g] && q.size() > 0) fifo_data <= q.pop_front();
      fifo_empty <= (q.size() == 0);
    end

    int         n;
    int         t0;
    int         next_free;
    logic       empty_seen;
    logic [7:0] cur;

    // Timeline model: a frame claimed at edge t0 drives the line from t0+2 for NB*CPB cycles
    always @(negedge clk) begin : model
      logic [2:0] e_out;
      int         k;
      if (!rst_n) begin
        n         = 0;
        t0        = -1000000;
        next_free = 0;
        cur       = 8'h00;
        e_out     = 3'b001;
      end else begin
        n++;
        if (n >= next_free && !empty_seen) begin
          t0        = n;
          next_free = n + 3 + NB * CPB;
          cur       = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        end
        k        = n - (t0 + 2);
        e_out[2] = (n == t0);
        e_out[1] = (n >= t0) && (n < t0 + 2 + NB * CPB);
        e_out[0] = (k >= 0 && k < NB * CPB) ? frame_bit(cur, k / CPB) : 1'b1;
      end
      check_eq($sformatf("inst%0d cyc%0d readen/busy/tx", g, n),
               {29'b0, readen_s[g], busy_s[g], tx_s[g]}, {29'b0, e_out});
      empty_seen = fifo_empty;
    end
  end

  task automatic push_byte(input int inst, input logic [7:0] b);
    case (inst)
      0: begin g_inst[0].q.push_back(b); g_inst[0].exp_q.push_back(b); end
      1: begin g_inst[1].q.push_back(b); g_inst[1].exp_q.push_back(b); end
      default: begin g_inst[2].q.push_back(b); g_inst[2].exp_q.push_back(b); end
    endcase
  endtask

  function automatic bit all_idle();
    return (g_inst[0].q.size() == 0) && (g_inst[1].q.size() == 0) &&
           (g_inst[2].q.size() == 0) && (g_inst[0].exp_q.size() == 0) &&
           (g_inst[1].exp_q.size() == 0) && (g_inst[2].exp_q.size() == 0) &&
           (busy_s == 3'b000) && (readen_s == 3'b000);
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (all_idle()) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Long idle with an empty FIFO: line must stay quiet
    repeat (10000) @(negedge clk);

    // Directed frames: A3/0F back-to-back, 00 with two stop bits, 55 at full baud divisor
    @(negedge clk);
    push_byte(0, 8'hA3);
    push_byte(0, 8'h0F);
    push_byte(1, 8'h00);
    push_byte(2, 8'h55);
    wait_idle("directed drain", 6000);

    // Random bursts with random gaps
    push_byte(2, 8'($urandom));
    push_byte(2, 8'($urandom));
    for (int it = 0; it < 30; it++) begin
      @(negedge clk);
      repeat ($urandom_range(0, 3)) push_byte(0, 8'($urandom));
      repeat ($urandom_range(0, 2)) push_byte(1, 8'($urandom));
      repeat ($urandom_range(0, 80)) @(negedge clk);
    end
    wait_idle("random drain", 20000);

    // Reset asserted while instance 0 is sending data bit 3
    @(negedge clk);
    push_byte(0, 8'($urandom));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (readen_s[0]) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("reset test readen seen", 32'(seen), 32'd1);
    repeat (2 + 4 * 4 + 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async reset tx", 32'(tx_s), 32'h7);
    check_eq("async reset busy", 32'(busy_s), 32'h0);
    check_eq("async reset readen", 32'(readen_s), 32'h0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("post reset idle", 32'(all_idle()), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
